// File: rtl/imul_share_arbiter_if.sv
// Bundle of requester-side and multiplier-side handshakes for the shared multiplier arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface imul_share_arbiter_if #(
  parameter int unsigned p_num_reqs = 4,
  parameter int unsigned p_nbits    = 32
);
  logic [p_num_reqs-1:0]           req_val;
  logic [p_num_reqs-1:0]           req_rdy;
  logic [p_num_reqs*2*p_nbits-1:0] req_msg;
  logic [p_num_reqs-1:0]           resp_val;
  logic [p_num_reqs-1:0]           resp_rdy;
  logic [p_nbits-1:0]              resp_msg;
  logic                            mul_req_val;
  logic                            mul_req_rdy;
  logic [2*p_nbits-1:0]            mul_req_msg;
  logic                            mul_resp_val;
  logic                            mul_resp_rdy;
  logic [p_nbits-1:0]              mul_resp_msg;
  logic [31:0]                     busy_cycles;

  modport slave (
    input  req_val, req_msg, resp_rdy, mul_req_rdy, mul_resp_val, mul_resp_msg,
    output req_rdy, resp_val, resp_msg, mul_req_val, mul_req_msg, mul_resp_rdy, busy_cycles
  );

  modport master (
    output req_val, req_msg, resp_rdy, mul_req_rdy, mul_resp_val, mul_resp_msg,
    input  req_rdy, resp_val, resp_msg, mul_req_val, mul_req_msg, mul_resp_rdy, busy_cycles
  );
endinterface

// File: rtl/imul_share_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among p_num_reqs requesters,
// one transaction in flight, product buffered until the owning requester accepts it.
module imul_share_arbiter #(
  parameter int unsigned p_num_reqs = 4,
  parameter int unsigned p_nbits    = 32
) (
  input logic                 clk,
  input logic                 reset,
  imul_share_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(p_num_reqs);
  localparam int unsigned MW = 2 * p_nbits;
  localparam logic [PW-1:0] LAST = PW'(p_num_reqs - 1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t             state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      grant;
  logic [PW-1:0]      idx;
  logic               any_val;
  logic [p_nbits-1:0] result;
  logic [31:0]        busy;

  // Scan from ptr upward, wrapping by explicit compare so non-power-of-two counts work.
  always_comb begin
    grant   = '0;
    any_val = 1'b0;
    idx     = ptr;
    for (int unsigned k = 0; k < p_num_reqs; k++) begin
      if (!any_val && bus.req_val[idx]) begin
        grant   = idx;
        any_val = 1'b1;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    bus.req_rdy  = '0;
    bus.resp_val = '0;
    if (state == IDLE) bus.req_rdy[grant] = any_val && bus.mul_req_rdy;
    if (state == HOLD) bus.resp_val[owner] = 1'b1;
  end

  assign bus.mul_req_val  = (state == IDLE) && any_val;
  assign bus.mul_req_msg  = any_val ? bus.req_msg[32'(grant)*MW +: MW] : '0;
  assign bus.mul_resp_rdy = (state == WAIT);
  assign bus.resp_msg     = result;
  assign bus.busy_cycles  = busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      result <= '0;
      busy   <= '0;
    end else begin
      if (state != IDLE && busy != '1) busy <= busy + 32'd1;
      case (state)
        IDLE: if (any_val && bus.mul_req_rdy) begin
          owner <= grant;
          ptr   <= (grant == LAST) ? '0 : grant + 1'b1;
          state <= WAIT;
        end
        WAIT: if (bus.mul_resp_val) begin
          result <= bus.mul_resp_msg;
          state  <= HOLD;
        end
        HOLD: if (bus.resp_rdy[owner]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
